// File: rtl/cn_pkg.sv
// Shared CN datapath definitions: MUL unit state encoding and sizing constants.
package cn_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        NEG_LO = 3'd2,
        NEG_HI = 3'd3,
        DONE   = 3'd4
    } mul_state_t;

    localparam int MUL_ITER = 8;
    localparam int MUL_W    = 8;

    // Two's-complement magnitude; 0x80 maps to 0x80, which is correct read as unsigned.
    function automatic logic [MUL_W-1:0] mul_abs(input logic [MUL_W-1:0] v);
        return v[MUL_W-1] ? (~v + {{(MUL_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/Adder.sv
// 8-bit adder with carry in/out; the only arithmetic resource of the MUL datapath.
module Adder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] Sum,
    output logic       Cout
);

    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {8'd0, Cin};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential 8x8 shift-and-add multiplier, start/done handshake, 9-cycle latency.
// SEQ_MULT_SIGNED_EN: two's-complement operands, result negated via the adder (11 cycles).
module seq_multiplier
    import cn_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    mul_state_t         state_q, state_d;
    logic [MUL_W-1:0]   m_q, m_d;
    logic [MUL_W-1:0]   acc_q, acc_d;
    logic [MUL_W-1:0]   q_q, q_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [2*MUL_W-1:0] prod_q, prod_d;
`ifdef SEQ_MULT_SIGNED_EN
    logic               c_q, c_d;
    logic               neg_q, neg_d;
`endif

    logic [MUL_W-1:0]   add_a, add_b, add_sum;
    logic               add_cin, add_cout;
    logic               last_iter;

    assign last_iter = (cnt_q == 3'(MUL_ITER - 1));

    Adder u_adder (
        .A    (add_a),
        .B    (add_b),
        .Cin  (add_cin),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            c_q     <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
`ifdef SEQ_MULT_SIGNED_EN
            c_q     <= c_d;
            neg_q   <= neg_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
`ifdef SEQ_MULT_SIGNED_EN
            RUN:     if (last_iter) state_d = NEG_LO;
`else
            RUN:     if (last_iter) state_d = DONE;
`endif
            NEG_LO:  state_d = NEG_HI;
            NEG_HI:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Adder input mux: partial-product add in RUN, ~x + carry for the negate stages.
    always_comb begin
        add_a   = acc_q;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            RUN:     add_b = q_q[0] ? m_q : '0;
`ifdef SEQ_MULT_SIGNED_EN
            NEG_LO:  begin add_a = ~q_q;   add_cin = 1'b1; end
            NEG_HI:  begin add_a = ~acc_q; add_cin = c_q;  end
`endif
            default: ;
        endcase
    end

    always_comb begin
        m_d    = m_q;
        acc_d  = acc_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
`ifdef SEQ_MULT_SIGNED_EN
        c_d    = c_q;
        neg_d  = neg_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                acc_d = '0;
                cnt_d = '0;
`ifdef SEQ_MULT_SIGNED_EN
                m_d   = mul_abs(a);
                q_d   = mul_abs(b);
                c_d   = 1'b0;
                neg_d = a[MUL_W-1] ^ b[MUL_W-1];
`else
                m_d   = a;
                q_d   = b;
`endif
            end
            RUN: begin
                // {C,ACC,Q} <= {Cout,Sum,Q} >> 1; C always lands at 0.
                acc_d = {add_cout, add_sum[MUL_W-1:1]};
                q_d   = {add_sum[0], q_q[MUL_W-1:1]};
                cnt_d = cnt_q + 3'd1;
`ifdef SEQ_MULT_SIGNED_EN
                c_d   = 1'b0;
`else
                if (last_iter) prod_d = {acc_d, q_d};
`endif
            end
`ifdef SEQ_MULT_SIGNED_EN
            NEG_LO: if (neg_q) begin
                q_d = add_sum;
                c_d = add_cout;
            end
            NEG_HI: begin
                if (neg_q) acc_d = add_sum;
                prod_d = {acc_d, q_q};
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        product = prod_q;
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (unsigned, plus signed vectors when SEQ_MULT_SIGNED_EN).
module tb_seq_multiplier;

`ifdef SEQ_MULT_SIGNED_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 9;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_tests = 0;
    int n_fail  = 0;

    seq_multiplier #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                          input logic [15:0] exp);
        int cyc;
        a     = aa;
        b     = bb;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 30) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, LAT);
        check({tag, " product"}, product, exp);
        check({tag, " busy in done"}, busy, 1'b1);
        tick();
        check({tag, " done drops"}, done, 1'b0);
        check({tag, " busy drops"}, busy, 1'b0);
        check({tag, " product holds"}, product, exp);
    endtask

    initial begin
        int n_done;
        logic [15:0] seen;

        rst = 1'b1;
        tick();
        tick();
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset product", product, 16'h0000);
        rst = 1'b0;
        tick();

        run_op("13x11", 8'h0D, 8'h0B, 16'h008F);
        run_op("ffxff", 8'hFF, 8'hFF, 16'hFE01);
        run_op("zero", 8'h00, 8'h5A, 16'h0000);
        run_op("ident", 8'h01, 8'hC3, 16'h00C3);

        // Extra start pulses during RUN (cycle 3) and in DONE must be ignored.
        a = 8'h0D; b = 8'h0B; start = 1'b1;
        tick();
        start  = 1'b0;
        n_done = 0;
        seen   = 16'hDEAD;
        for (int cyc = 1; cyc < 25; cyc++) begin
            if (done) begin
                n_done++;
                seen = product;
            end
            if (cyc == 3 || cyc == LAT) begin
                a = 8'h77; b = 8'h99; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("ignored start done count", n_done, 1);
        check("ignored start product", seen, 16'h008F);
        check("ignored start idle", busy, 1'b0);

        // Abort with reset in cycle 5.
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 5; cyc++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort product", product, 16'h0000);
        n_done = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            if (done) n_done++;
            tick();
        end
        check("abort no done", n_done, 0);
        run_op("2x3", 8'h02, 8'h03, 16'h0006);

        // Reset and start together: request dropped.
        rst = 1'b1; start = 1'b1; a = 8'h05; b = 8'h05;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        check("rst+start busy", busy, 1'b0);
        n_done = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            if (done) n_done++;
            tick();
        end
        check("rst+start no done", n_done, 0);
        check("rst+start product", product, 16'h0000);

`ifdef SEQ_MULT_SIGNED_EN
        run_op("s -3x5", 8'hFD, 8'h05, 16'hFFF1);
        run_op("s -128x-128", 8'h80, 8'h80, 16'h4000);
        run_op("s -128x1", 8'h80, 8'h01, 16'hFF80);
        run_op("s -1x-1", 8'hFF, 8'hFF, 16'h0001);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
